// File: rtl/alu_seq_control_fsm_pkg.sv
// Shared encodings for the ALU sequencer: operation codes, one-hot state
// indices and the Booth digit decode used by the next-state logic.
package alu_seq_control_fsm_pkg;

    localparam int unsigned NUM_STATES  = 16;
    localparam int unsigned STATE_IDX_W = 4;
    localparam int unsigned OP_W        = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    localparam int unsigned S_IDLE    = 0;
    localparam int unsigned S_LOAD    = 1;
    localparam int unsigned S_ADD     = 2;
    localparam int unsigned S_SUB     = 3;
    localparam int unsigned S_BPOS    = 4;
    localparam int unsigned S_RSHIFT  = 5;
    localparam int unsigned S_BNEG    = 6;
    localparam int unsigned S_COUNT   = 7;
    localparam int unsigned S_NORM    = 8;
    localparam int unsigned S_DZERO   = 9;
    localparam int unsigned S_DNEG    = 10;
    localparam int unsigned S_DPOS    = 11;
    localparam int unsigned S_CORR    = 12;
    localparam int unsigned S_DSHIFT  = 13;
    localparam int unsigned S_FIX     = 14;
    localparam int unsigned S_DONE    = 15;

    typedef logic [NUM_STATES-1:0] state_vec_t;

    typedef enum logic [1:0] {
        DIG_ZERO = 2'b00,
        DIG_POS  = 2'b01,
        DIG_NEG  = 2'b10
    } booth_dig_e;

    function automatic state_vec_t onehot(input int unsigned idx);
        state_vec_t v;
        v = '0;
        v[idx[STATE_IDX_W-1:0]] = 1'b1;
        return v;
    endfunction

    // b1 wins over b0 wins over bminus1; no strobe at all counts as a zero digit
    function automatic booth_dig_e booth_digit(input logic b1, input logic b0, input logic bm1);
        booth_dig_e d;
        if (b1)       d = DIG_POS;
        else if (b0)  d = DIG_ZERO;
        else if (bm1) d = DIG_NEG;
        else          d = DIG_ZERO;
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_control_fsm_state_reg.sv
// One-hot state register; reset lands on the idle state (bit 0).
module alu_seq_control_fsm_state_reg
    import alu_seq_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  state_vec_t d_i,
    output state_vec_t q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_o <= state_vec_t'(16'h0001);
        else        q_o <= d_i;
    end

endmodule

// File: rtl/alu_seq_control_fsm.sv
// Moore control sequencer for the 8-bit ALU datapath: add, sub, radix-4
// Booth multiply and SRT-style divide, driving load/shift/count/select strobes.
module alu_seq_control_fsm
    import alu_seq_control_fsm_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic            bgn,
    input  logic            a8,
    input  logic            b1,
    input  logic            b0,
    input  logic            bminus1,
    input  logic            m7,
    input  logic            cnt0,
    input  logic            cnt7,
    output logic            endd,
    output logic            load_A,
    output logic            load_Q,
    output logic            load_M,
    output logic            load_QP,
    output logic            load_cnt,
    output logic            rshift_A,
    output logic            rshift_Q,
    output logic            lshift_A,
    output logic            lshift_Q,
    output logic            lshift_M,
    output logic            lshift_QP,
    output logic            c_up_1,
    output logic            c_up_2,
    output logic            c_up_QP,
    output logic            c_down_1,
    output logic            sel_mux_1,
    output logic            sel_mux_2,
    output logic            sel_mux_3,
    output logic            sel_mux_5,
    output logic            sel_mux_6,
    output logic            sel_mux_7,
    output logic            sel_demux_1,
    output logic            sel_demux_2,
    output logic            sel_demux_3,
    output logic            booth_digit_for_Q,
    output logic            booth_digit_for_QP,
    output logic            exor_in,
    output logic            a7_mem
);

    state_vec_t state_q;
    state_vec_t state_d;
    booth_dig_e digit;
    state_vec_t mul_step;
    state_vec_t div_step;
    state_vec_t div_tail;

    alu_seq_control_fsm_state_reg u_state_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (state_d),
        .q_o   (state_q)
    );

    // Next-state logic; mul_step/div_step pick the Booth-digit branch, div_tail the post-loop correction
    always_comb begin
        state_d  = onehot(S_IDLE);
        digit    = booth_digit(b1, b0, bminus1);
        mul_step = onehot(S_RSHIFT);
        div_step = onehot(S_DZERO);
        div_tail = a8 ? onehot(S_CORR) : (cnt0 ? onehot(S_FIX) : onehot(S_DSHIFT));

        case (digit)
            DIG_POS: begin
                mul_step = onehot(S_BPOS);
                div_step = onehot(S_DPOS);
            end
            DIG_NEG: begin
                mul_step = onehot(S_BNEG);
                div_step = onehot(S_DNEG);
            end
            default: ;
        endcase

        case (1'b1)
            state_q[S_IDLE]:   state_d = bgn ? onehot(S_LOAD) : onehot(S_IDLE);
            state_q[S_LOAD]: begin
                case (op_e'(op))
                    OP_ADD:  state_d = onehot(S_ADD);
                    OP_SUB:  state_d = onehot(S_SUB);
                    OP_MUL:  state_d = mul_step;
                    default: state_d = m7 ? div_step : onehot(S_NORM);
                endcase
            end
            state_q[S_ADD],
            state_q[S_SUB]:    state_d = onehot(S_DONE);
            state_q[S_BPOS],
            state_q[S_BNEG]: begin
                if (!op[0])     state_d = onehot(S_RSHIFT);
                else if (!cnt7) state_d = onehot(S_COUNT);
                else            state_d = div_tail;
            end
            state_q[S_RSHIFT]: state_d = cnt7 ? onehot(S_DONE) : onehot(S_COUNT);
            state_q[S_COUNT]:  state_d = op[0] ? div_step : mul_step;
            state_q[S_NORM]:   state_d = m7 ? div_step : onehot(S_NORM);
            state_q[S_DZERO]:  state_d = cnt7 ? div_tail : onehot(S_COUNT);
            state_q[S_DNEG]:   state_d = onehot(S_BPOS);
            state_q[S_DPOS]:   state_d = onehot(S_BNEG);
            state_q[S_CORR]:   state_d = onehot(S_DSHIFT);
            state_q[S_DSHIFT]: state_d = cnt0 ? onehot(S_FIX) : onehot(S_DSHIFT);
            state_q[S_FIX]:    state_d = onehot(S_DONE);
            state_q[S_DONE]:   state_d = bgn ? onehot(S_LOAD) : onehot(S_DONE);
            default:           state_d = onehot(S_IDLE);
        endcase
    end

    assign load_A    = state_q[S_LOAD] | state_q[S_BPOS] | state_q[S_BNEG] | state_q[S_CORR];
    assign load_Q    = state_q[S_LOAD] | state_q[S_ADD] | state_q[S_SUB] | state_q[S_FIX];
    assign load_M    = state_q[S_LOAD];
    assign load_QP   = state_q[S_LOAD];
    assign load_cnt  = state_q[S_LOAD];

    assign rshift_A  = state_q[S_RSHIFT] | state_q[S_DSHIFT];
    assign rshift_Q  = state_q[S_RSHIFT];
    assign lshift_A  = state_q[S_NORM] | state_q[S_DZERO] | state_q[S_DNEG] | state_q[S_DPOS];
    assign lshift_Q  = lshift_A;
    assign lshift_M  = state_q[S_NORM];
    assign lshift_QP = state_q[S_DZERO] | state_q[S_DNEG] | state_q[S_DPOS];

    assign c_up_1    = state_q[S_NORM];
    assign c_up_2    = state_q[S_COUNT];
    assign c_up_QP   = state_q[S_CORR];
    assign c_down_1  = state_q[S_DSHIFT];

    // Result write-back path shared by add, sub and the divide fix-up
    assign sel_mux_1   = state_q[S_BPOS] | state_q[S_BNEG] | state_q[S_CORR];
    assign sel_mux_2   = state_q[S_ADD] | state_q[S_SUB] | state_q[S_FIX];
    assign sel_mux_5   = sel_mux_2;
    assign sel_demux_1 = sel_mux_2;
    assign sel_demux_3 = sel_mux_2;
    assign sel_mux_3   = state_q[S_FIX];
    assign sel_demux_2 = state_q[S_DONE];

    assign booth_digit_for_Q  = state_q[S_DPOS];
    assign booth_digit_for_QP = state_q[S_DNEG];
    assign exor_in            = state_q[S_SUB] | state_q[S_BNEG] | state_q[S_FIX];
    assign endd               = state_q[S_DONE];

    // Op-decoded selects follow op directly, independent of state
    assign sel_mux_6 = op[0];
    assign sel_mux_7 = ~op[1];
    assign a7_mem    = op[1] & ~op[0];

endmodule

// File: tb/tb_alu_seq_control_fsm.sv
// Self-checking bench for alu_seq_control_fsm: directed sequences per operation
// plus a randomized run against a state-number reference model.
module tb_alu_seq_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [1:0] op;
    logic       bgn, a8, b1, b0, bminus1, m7, cnt0, cnt7;
    logic       endd, load_A, load_Q, load_M, load_QP, load_cnt;
    logic       rshift_A, rshift_Q, lshift_A, lshift_Q, lshift_M, lshift_QP;
    logic       c_up_1, c_up_2, c_up_QP, c_down_1;
    logic       sel_mux_1, sel_mux_2, sel_mux_3, sel_mux_5, sel_mux_6, sel_mux_7;
    logic       sel_demux_1, sel_demux_2, sel_demux_3;
    logic       booth_digit_for_Q, booth_digit_for_QP, exor_in, a7_mem;

    int total = 0;
    int bad   = 0;
    int ms    = 0;

    alu_seq_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .bgn(bgn), .a8(a8), .b1(b1), .b0(b0),
        .bminus1(bminus1), .m7(m7), .cnt0(cnt0), .cnt7(cnt7), .endd(endd),
        .load_A(load_A), .load_Q(load_Q), .load_M(load_M), .load_QP(load_QP),
        .load_cnt(load_cnt), .rshift_A(rshift_A), .rshift_Q(rshift_Q),
        .lshift_A(lshift_A), .lshift_Q(lshift_Q), .lshift_M(lshift_M),
        .lshift_QP(lshift_QP), .c_up_1(c_up_1), .c_up_2(c_up_2), .c_up_QP(c_up_QP),
        .c_down_1(c_down_1), .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2),
        .sel_mux_3(sel_mux_3), .sel_mux_5(sel_mux_5), .sel_mux_6(sel_mux_6),
        .sel_mux_7(sel_mux_7), .sel_demux_1(sel_demux_1), .sel_demux_2(sel_demux_2),
        .sel_demux_3(sel_demux_3), .booth_digit_for_Q(booth_digit_for_Q),
        .booth_digit_for_QP(booth_digit_for_QP), .exor_in(exor_in), .a7_mem(a7_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [25:0] act_outs();
        return {exor_in, booth_digit_for_QP, booth_digit_for_Q, sel_demux_3, sel_demux_2,
                sel_demux_1, sel_mux_5, sel_mux_3, sel_mux_2, sel_mux_1, c_down_1, c_up_QP,
                c_up_2, c_up_1, lshift_QP, lshift_M, lshift_Q, lshift_A, rshift_Q, rshift_A,
                load_cnt, load_QP, load_M, load_Q, load_A, endd};
    endfunction

    // Expected strobe vector for a state number, same bit order as act_outs
    function automatic logic [25:0] exp_outs(input int s);
        logic [25:0] e;
        bit wb;
        wb     = s inside {2, 3, 14};
        e[0]   = (s == 15);
        e[1]   = s inside {1, 4, 6, 12};
        e[2]   = s inside {1, 2, 3, 14};
        e[3]   = (s == 1);
        e[4]   = (s == 1);
        e[5]   = (s == 1);
        e[6]   = s inside {5, 13};
        e[7]   = (s == 5);
        e[8]   = s inside {8, 9, 10, 11};
        e[9]   = s inside {8, 9, 10, 11};
        e[10]  = (s == 8);
        e[11]  = s inside {9, 10, 11};
        e[12]  = (s == 8);
        e[13]  = (s == 7);
        e[14]  = (s == 12);
        e[15]  = (s == 13);
        e[16]  = s inside {4, 6, 12};
        e[17]  = wb;
        e[18]  = (s == 14);
        e[19]  = wb;
        e[20]  = wb;
        e[21]  = (s == 15);
        e[22]  = wb;
        e[23]  = (s == 11);
        e[24]  = (s == 10);
        e[25]  = s inside {3, 6, 14};
        return e;
    endfunction

    function automatic logic [2:0] exp_opsel(input logic [1:0] o);
        // {a7_mem, sel_mux_7, sel_mux_6}: multiply-only, add/sub-only, sub/div
        return {o == 2'b10, o inside {2'b00, 2'b01}, o inside {2'b01, 2'b11}};
    endfunction

    // Reference next state, written from the transition table in state numbers
    function automatic int model_next(input int s, input logic [1:0] o, input bit g,
                                      input bit sa8, input bit sb1, input bit sb0,
                                      input bit sbm1, input bit sm7, input bit c0, input bit c7);
        int d, mul_t, div_t, tail;
        d     = sb1 ? 1 : (sb0 ? 0 : (sbm1 ? -1 : 0));
        mul_t = (d > 0) ? 4 : ((d < 0) ? 6 : 5);
        div_t = (d > 0) ? 11 : ((d < 0) ? 10 : 9);
        tail  = sa8 ? 12 : (c0 ? 14 : 13);
        case (s)
            0:       return g ? 1 : 0;
            1:       return (o == 2'd0) ? 2 : (o == 2'd1) ? 3 : (o == 2'd2) ? mul_t : (sm7 ? div_t : 8);
            2, 3:    return 15;
            4, 6:    return (o[0] == 1'b0) ? 5 : (!c7 ? 7 : tail);
            5:       return c7 ? 15 : 7;
            7:       return o[0] ? div_t : mul_t;
            8:       return sm7 ? div_t : 8;
            9:       return c7 ? tail : 7;
            10:      return 4;
            11:      return 6;
            12:      return 13;
            13:      return c0 ? 14 : 13;
            14:      return 15;
            default: return bgn_hold(g);
        endcase
    endfunction

    function automatic int bgn_hold(input bit g);
        return g ? 1 : 15;
    endfunction

    function automatic logic [9:0] mk(input logic [1:0] o, input bit g, input bit sa8,
                                      input bit sb1, input bit sb0, input bit sbm1,
                                      input bit sm7, input bit c0, input bit c7);
        return {o, g, sa8, sb1, sb0, sbm1, sm7, c0, c7};
    endfunction

    task automatic drive(input logic [9:0] v);
        {op, bgn, a8, b1, b0, bminus1, m7, cnt0, cnt7} = v;
    endtask

    task automatic tick();
        int n;
        n = model_next(ms, op, bgn, a8, b1, b0, bminus1, m7, cnt0, cnt7);
        @(posedge clk);
        ms = n;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ms    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(mk(2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        #3;
        ms = 0;
        total++;
        if (act_outs() !== exp_outs(0)) begin
            $display("FAIL reset_outs got=%h want=%h", act_outs(), exp_outs(0));
            bad++;
        end
        total++;
        if ({a7_mem, sel_mux_7, sel_mux_6} !== 3'b100) begin
            $display("FAIL reset_opsel got=%b want=100", {a7_mem, sel_mux_7, sel_mux_6});
            bad++;
        end
        for (int o = 0; o < 4; o++) begin
            op = 2'(o);
            #1;
            total++;
            if ({a7_mem, sel_mux_7, sel_mux_6} !== exp_opsel(op)) begin
                $display("FAIL opsel op=%0d got=%b want=%b", o, {a7_mem, sel_mux_7, sel_mux_6}, exp_opsel(op));
                bad++;
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (act_outs() !== exp_outs(0)) begin
            $display("FAIL reset_held got=%h want=%h", act_outs(), exp_outs(0));
            bad++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        logic [9:0] stim[$];
        int         want[$];
        stim = '{mk(0,1,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0),
                 mk(0,0,0,0,0,0,0,0,0), mk(0,0,0,0,0,0,0,0,0),
                 mk(1,1,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,0), mk(1,0,0,0,0,0,0,0,0)};
        want = '{1, 2, 15, 15, 15, 1, 3, 15};
        do_reset();
        foreach (stim[i]) begin
            drive(stim[i]);
            tick();
            total++;
            if (act_outs() !== exp_outs(want[i])) begin
                $display("FAIL addsub step=%0d got=%h want=%h (S%0d)", i, act_outs(), exp_outs(want[i]), want[i]);
                bad++;
            end
        end
    endtask

    task automatic test_mul();
        logic [9:0] stim[$];
        int         want[$];
        stim = '{mk(2,1,0,0,0,0,0,0,0), mk(2,0,0,1,0,0,0,0,0), mk(2,0,0,0,0,0,0,0,0),
                 mk(2,0,0,0,0,0,0,0,0), mk(2,0,0,0,0,1,0,0,0), mk(2,0,0,0,0,0,0,0,0),
                 mk(2,0,0,0,0,0,0,0,1), mk(2,0,0,0,0,0,0,0,0)};
        want = '{1, 4, 5, 7, 6, 5, 15, 15};
        do_reset();
        foreach (stim[i]) begin
            drive(stim[i]);
            tick();
            total++;
            if (act_outs() !== exp_outs(want[i])) begin
                $display("FAIL mul step=%0d got=%h want=%h (S%0d)", i, act_outs(), exp_outs(want[i]), want[i]);
                bad++;
            end
        end
    endtask

    task automatic test_div();
        logic [9:0] stim[$];
        int         want[$];
        stim = '{mk(3,1,0,0,0,0,0,0,0), mk(3,0,0,0,0,0,0,0,0), mk(3,0,0,0,0,0,0,0,0),
                 mk(3,0,0,0,0,1,1,0,0), mk(3,0,0,0,0,0,1,0,0), mk(3,0,1,0,0,0,1,0,1),
                 mk(3,0,0,0,0,0,1,0,0), mk(3,0,0,0,0,0,1,0,0), mk(3,0,0,0,0,0,1,1,0),
                 mk(3,0,0,0,0,0,1,0,0), mk(3,1,0,0,0,0,1,0,0)};
        want = '{1, 8, 8, 10, 4, 12, 13, 13, 14, 15, 1};
        do_reset();
        foreach (stim[i]) begin
            drive(stim[i]);
            tick();
            total++;
            if (act_outs() !== exp_outs(want[i])) begin
                $display("FAIL div step=%0d got=%h want=%h (S%0d)", i, act_outs(), exp_outs(want[i]), want[i]);
                bad++;
            end
        end
    endtask

    task automatic test_midop_reset();
        do_reset();
        drive(mk(3,1,0,0,0,0,0,0,0));
        tick();
        drive(mk(3,0,0,0,0,0,0,0,0));
        tick();
        #2;
        rst_n = 1'b0;
        ms    = 0;
        #1;
        total++;
        if (act_outs() !== exp_outs(0)) begin
            $display("FAIL midop_reset got=%h want=%h", act_outs(), exp_outs(0));
            bad++;
        end
        drive(mk(3,1,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        total++;
        if (act_outs() !== exp_outs(0)) begin
            $display("FAIL reset_ignores_bgn got=%h want=%h", act_outs(), exp_outs(0));
            bad++;
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (act_outs() !== exp_outs(1)) begin
            $display("FAIL restart_after_reset got=%h want=%h", act_outs(), exp_outs(1));
            bad++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (ms == 0 || ms == 15) op = 2'($urandom_range(3));
            bgn     = ($urandom_range(3) == 0);
            a8      = 1'($urandom);
            b1      = 1'($urandom);
            b0      = 1'($urandom);
            bminus1 = 1'($urandom);
            m7      = ($urandom_range(2) != 0);
            cnt0    = 1'($urandom);
            cnt7    = ($urandom_range(3) == 0);
            tick();
            total++;
            if (act_outs() !== exp_outs(ms) || {a7_mem, sel_mux_7, sel_mux_6} !== exp_opsel(op)) begin
                $display("FAIL random cyc=%0d S%0d op=%0d got=%h/%b want=%h/%b", i, ms, op,
                         act_outs(), {a7_mem, sel_mux_7, sel_mux_6}, exp_outs(ms), exp_opsel(op));
                bad++;
            end
            if ($urandom_range(199) == 0) begin
                rst_n = 1'b0;
                ms    = 0;
                #1;
                total++;
                if (act_outs() !== exp_outs(0)) begin
                    $display("FAIL random_reset cyc=%0d got=%h want=%h", i, act_outs(), exp_outs(0));
                    bad++;
                end
                #1;
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive('0);
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_midop_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_control_fsm.md
Name: alu_seq_control_fsm

Overview:
- Moore-style control sequencer for the 8-bit ALU datapath (registers A, Q, M, Q', counter).
- Supports add (op=00), subtract (01), radix-4 Booth multiply (10) and SRT-style divide (11).
- Holds 16 one-hot states and drives register load/shift/select/count strobes from the current state only.
- The exceptions are the three op-decoded selects, which are combinational from op.

Parameters:
- none (fixed 16-state one-hot encoding)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset, forces S0
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- bgn  in  1  start request
- a8  in  1  A[8] sign, division correction
- b1, b0, bminus1  in  1 each  Booth digit is +1 / 0 / -1
- m7  in  1  M[7] (divisor normalised when 1)
- cnt0  in  1  down-counter reached zero (division)
- cnt7  in  1  up-counter reached terminal count
- endd  out  1  done (S15)
- load_A, load_Q, load_M, load_QP, load_cnt  out  1  register loads
- rshift_A, rshift_Q, lshift_A, lshift_Q, lshift_M, lshift_QP  out  1  shift strobes
- c_up_1, c_up_2, c_up_QP, c_down_1  out  1  counter strobes
- sel_mux_1, sel_mux_2, sel_mux_3, sel_mux_5, sel_mux_6, sel_mux_7  out  1  mux selects
- sel_demux_1, sel_demux_2, sel_demux_3  out  1  demux selects
- booth_digit_for_Q, booth_digit_for_QP, exor_in, a7_mem  out  1  datapath controls

Behaviour:
- **State register**
  - 16-bit one-hot, S0..S15.
  - rst_n low forces S0 asynchronously; exactly one bit is set at all times.
  - Transitions occur on the rising clk edge.
- **Booth digit priority:** b1 > b0 > bminus1. If none is asserted, treat it as b0.
- **Next state**
  - S0: bgn→S1, else S0.
  - S1: op=00→S2. op=01→S3. op=10: +1→S4, 0→S5, -1→S6. op=11: m7=0→S8, else +1→S11, 0→S9, -1→S10.
  - S2, S3→S15.
  - S4, S6:
    - op[0]=0→S5.
    - op[0]=1 with cnt7=0→S7.
    - op[0]=1 with cnt7=1: a8=1→S12; a8=0 and cnt0=0→S13; a8=0 and cnt0=1→S14.
  - S5: cnt7→S15, else S7.
  - S7: op[0]=0: +1→S4, 0→S5, -1→S6. op[0]=1: +1→S11, 0→S9, -1→S10.
  - S8: m7=0→S8, else +1→S11, 0→S9, -1→S10.
  - S9: cnt7=0→S7, else same as the S4 op[0]=1 cnt7=1 branch.
  - S10→S4. S11→S6. S12→S13.
  - S13: cnt0→S14, else S13.
  - S14→S15.
  - S15: bgn→S1, else S15.
- **Outputs, state-decoded**
  - load_A=S1|S4|S6|S12; load_Q=S1|S2|S3|S14; load_M=load_QP=load_cnt=S1.
  - rshift_A=S5|S13; rshift_Q=S5.
  - lshift_A=lshift_Q=S8|S9|S10|S11; lshift_M=S8; lshift_QP=S9|S10|S11.
  - c_up_1=S8; c_up_2=S7; c_up_QP=S12; c_down_1=S13.
  - sel_mux_1=S4|S6|S12; sel_mux_2=sel_mux_5=sel_demux_1=sel_demux_3=S2|S3|S14; sel_mux_3=S14; sel_demux_2=S15.
  - booth_digit_for_Q=S11; booth_digit_for_QP=S10; exor_in=S3|S6|S14; endd=S15.
- **Outputs, op-decoded (combinational):** sel_mux_6=op[0]; sel_mux_7=~op[1]; a7_mem=op[1]&~op[0].
- **Reset values:** all state-decoded outputs are 0 (S0).
- **Boundary rules**
  - bgn is sampled only in S0 and S15.
  - Reset mid-operation aborts to S0 immediately.
  - op must be held stable from S1 until endd.

Decomposition:
- Shared package: op encodings (OP_ADD/SUB/MUL/DIV) and state bit indices S_IDLE..S_DONE (0..15).
- One natural sub-module, ctrl_state_reg: 16-bit async-active-low-reset register, reset value 16'h0001.

Test Plan:
- Reset: rst_n=0 → state S0, all state-decoded outputs 0; op=10 → a7_mem=1, sel_mux_7=0, sel_mux_6=0.
- Add: op=00, bgn pulse → S1 (load_A/Q/M=1), S2 (sel_mux_2=1), S15 (endd=1, sel_demux_2=1), holds while bgn=0.
- Sub: op=01 → S1, S3 (exor_in=1, load_Q=1), S15.
- Multiply: op=10, b1=1, cnt7=0 → S1, S4, S5 (rshift_A/Q), S7 (c_up_2); then bminus1 → S6, S5; cnt7=1 in S5 → S15.
- Divide normalise: op=11, m7=0 → S8 repeats (lshift_M, c_up_1); m7=1, bminus1 → S10 → S4; cnt7=1, a8=1, cnt0=0 → S12 (c_up_QP) → S13.
- Divide finish: S13 with cnt0=0 stays (c_down_1); cnt0=1 → S14 (sel_mux_3, exor_in) → S15; bgn=1 in S15 → S1.
